addsub_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares the single registered add/subtract unit of the small processor among four requesters. It accepts one operation at a time through per-requester valid/ready handshakes and drives the operands into the adder. It accounts for the adder's one-cycle input-register latency and returns the tagged result on a shared response channel with back-pressure. It sits between the decode/execute clients and the adder instance at processor top level.

---
 rtl/addsub_arbiter.sv | 113 +++++++++++
 tb/tb_addsub_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sequencer sharing one registered add/sub unit among four requesters
module addsub_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_op,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    output logic                          add_op,
    input  logic [DATA_WIDTH-1:0]         add_data,
    input  logic                          add_over,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_over,
    output logic                          busy
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              grant_id, cand;
    logic                    grant_valid;
    logic [DATA_WIDTH-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
    logic                    add_op_q, add_op_d;
    logic [1:0]              rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_over_q, rsp_over_d;

    // Pick the first valid requester at or after the rotating pointer; the lowest offset wins
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 2'd0;
        cand        = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_q + k[1:0];
            if (req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign req_ready = (rst_n && state_q == IDLE && grant_valid) ? NUM_REQ'(1) << grant_id : '0;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_op    = add_op_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_over  = rsp_over_q;
    assign busy      = state_q != IDLE;

    // Sequence one operation at a time: accept, let the adder register operands, capture, respond
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_op_d   = add_op_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_over_d = rsp_over_q;
        case (state_q)
            IDLE: if (grant_valid) begin
                state_d  = EXEC;
                ptr_d    = grant_id + 2'd1;
                add_a_d  = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
                add_b_d  = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
                add_op_d = req_op[grant_id];
                rsp_id_d = grant_id;
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                rsp_data_d = add_data;
                rsp_over_d = add_over;
                state_d    = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation without a response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_op_q   <= 1'b0;
            rsp_id_q   <= 2'd0;
            rsp_data_q <= '0;
            rsp_over_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_op_q   <= add_op_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_over_q <= rsp_over_d;
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: scoreboard bench with a registered adder model behind the arbiter
module tb_addsub_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_op = '0;
    logic [15:0] add_a, add_b, add_data;
    logic        add_op, add_over;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_over;
    logic        busy;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] d;
        logic        o;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    int          alog[$];
    int          cyc = 0;
    int          stalls = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_data;
    logic        last_over;
    int          last_rsp_cyc = 0;
    logic [15:0] ar = '0, br = '0;

    addsub_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .add_a(add_a), .add_b(add_b), .add_op(add_op),
        .add_data(add_data), .add_over(add_over),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_over(rsp_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // Adder: operands registered on the clock, op applied combinationally at the output
    always @(posedge clk) begin
        ar <= add_a;
        br <= add_b;
    end
    assign {add_over, add_data} = add_op ? {1'b0, ar} + {1'b0, ~br} + 17'd1 : {1'b0, ar} + {1'b0, br};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] a, b;
        int id;
        if (!rst_n) begin
            sb.delete();
            stalls = 0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.d);
                    chk("rsp_over", rsp_over, e.o);
                    chk("latency", cyc - e.c, 3 + stalls);
                end
                last_data = rsp_data;
                last_over = rsp_over;
                last_rsp_cyc = cyc;
            end
            if (rsp_valid && !rsp_ready) stalls++;
            if ((req_valid & req_ready) != 0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                id = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
                a = req_a[id*16 +: 16];
                b = req_b[id*16 +: 16];
                e.id = id[1:0];
                e.c = cyc;
                if (req_op[id]) begin
                    e.d = a - b;
                    e.o = a >= b;
                end else begin
                    e.d = a + b;
                    e.o = (32'(a) + 32'(b)) > 32'hFFFF;
                end
                sb.push_back(e);
                stalls = 0;
                glog.push_back(id);
                alog.push_back(cyc);
            end
        end
    end

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic op);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        req_op[id] = op;
    endtask

    task automatic wait_acc(input int id);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready[id]) break;
        end
        if (n == 60) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 60; n++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        if (n == 60) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_grants(input int cnt);
        int n;
        for (n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (glog.size() >= cnt) break;
        end
        if (n == 200) chk("grant_timeout", glog.size(), cnt);
    endtask

    task automatic op1(input int id, input logic [15:0] a, input logic [15:0] b, input logic op);
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        wait_acc(id);
        req_valid[id] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        int exp_pair[3] = '{3, 1, 3};
        logic [15:0] s_data;
        logic s_over;
        logic [1:0] s_id;
        int n;

        set_req(0, 16'h0003, 16'h0004, 1'b0);
        req_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("c0_ready", req_ready, 4'b0001);
        chk("c0_busy", busy, 0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("single_busy", busy, 1);
            chk("single_rsp_valid", rsp_valid, k == 3);
        end
        @(posedge clk);
        #1 wait_idle();
        chk("add_data", last_data, 16'h0007);
        chk("add_over", last_over, 0);

        op1(2, 16'hFFFF, 16'h0001, 1'b0);
        chk("ovf_data", last_data, 16'h0000);
        chk("ovf_over", last_over, 1);
        op1(2, 16'h0005, 16'h0003, 1'b1);
        chk("sub_data", last_data, 16'h0002);
        chk("sub_over", last_over, 1);
        op1(2, 16'h0003, 16'h0005, 1'b1);
        chk("subneg_data", last_data, 16'hFFFE);
        chk("subneg_over", last_over, 0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'(i * 16'h1111 + 1), 16'(i * 16'h0101), i[0]);
        glog.delete();
        alog.delete();
        req_valid = 4'b1111;
        wait_grants(5);
        req_valid = 4'b0000;
        wait_idle();
        for (int i = 0; i < 5; i++) chk("rr_grant", glog[i], exp_rr[i]);
        for (int i = 1; i < 5; i++) chk("rr_spacing", alog[i] - alog[i-1], 4);

        op1(1, 16'h8000, 16'h8000, 1'b0);
        glog.delete();
        req_valid = 4'b1010;
        wait_grants(3);
        req_valid = 4'b0000;
        wait_idle();
        for (int i = 0; i < 3; i++) chk("pair_grant", glog[i], exp_pair[i]);

        rsp_ready = 1'b0;
        set_req(0, 16'h1234, 16'h0F0F, 1'b0);
        req_valid[0] = 1'b1;
        wait_acc(0);
        req_valid = 4'b0010;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (n == 20) chk("bp_rsp_timeout", 32'd0, 32'd1);
        s_data = rsp_data;
        s_over = rsp_over;
        s_id = rsp_id;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, s_data);
            chk("bp_over", rsp_over, s_over);
            chk("bp_id", rsp_id, s_id);
            chk("bp_ready", req_ready, 4'b0000);
        end
        glog.delete();
        alog.delete();
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grants(1);
        req_valid = 4'b0000;
        chk("bp_next_grant", glog[0], 1);
        chk("bp_next_gap", alog[0] - last_rsp_cyc, 1);
        wait_idle();

        set_req(0, 16'h00AA, 16'h0055, 1'b0);
        req_valid[0] = 1'b1;
        wait_acc(0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 4'b0000);
        @(negedge clk);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_add_b", add_b, 0);
        set_req(2, 16'h0010, 16'h0001, 1'b1);
        req_valid = 4'b0101;
        glog.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_grants(1);
        req_valid = 4'b0000;
        chk("post_rst_grant", glog[0], 0);
        wait_idle();
        repeat (8) @(posedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
